// File: rtl/instruction_encoder.sv
// RISC-V instruction word encoder: two-stage pipeline, request in S1, encoded word in S2, latency 2 cycles.
// Valid/ready on both ports; a stalled S2 holds its word and stalls S1, so in_ready drops only when both are full.
module instruction_encoder #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_err,
  output logic [15:0]     instr_count,
  output logic [7:0]      err_count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic            r_s1_vld;
  logic [2:0]      r_s1_fmt;
  logic [6:0]      r_s1_opcode;
  logic [4:0]      r_s1_rd;
  logic [4:0]      r_s1_rs1;
  logic [4:0]      r_s1_rs2;
  logic [2:0]      r_s1_funct3;
  logic [6:0]      r_s1_funct7;
  logic [XLEN-1:0] r_s1_imm;

  logic            r_s2_vld;
  logic [31:0]     r_s2_instr;
  logic            r_s2_err;
  logic [15:0]     r_instr_cnt;
  logic [7:0]      r_err_cnt;

  logic            w_s2_load;
  logic            w_in_xfer;
  logic            w_imm_i_ok;
  logic            w_imm_b_ok;
  logic            w_imm_u_ok;
  logic            w_imm_j_ok;
  logic [31:0]     w_enc_instr;
  logic            w_enc_err;

  // S1 advances whenever S2 can take a word, even if S1 is empty (that just clears S2).
  assign w_s2_load = !r_s2_vld || out_ready;
  assign in_ready  = !r_s1_vld || w_s2_load;
  assign w_in_xfer = in_valid && in_ready;

  assign w_imm_i_ok = (&r_s1_imm[XLEN-1:11]) || !(|r_s1_imm[XLEN-1:11]);
  assign w_imm_b_ok = !r_s1_imm[0] && ((&r_s1_imm[XLEN-1:12]) || !(|r_s1_imm[XLEN-1:12]));
  assign w_imm_u_ok = !(|r_s1_imm[11:0]) && ((&r_s1_imm[XLEN-1:31]) || !(|r_s1_imm[XLEN-1:31]));
  assign w_imm_j_ok = !r_s1_imm[0] && ((&r_s1_imm[XLEN-1:20]) || !(|r_s1_imm[XLEN-1:20]));

  always_comb begin
    w_enc_instr = 32'h0;
    w_enc_err   = 1'b0;
    case (r_s1_fmt)
      FMT_R: w_enc_instr = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
      FMT_I: begin
        w_enc_instr = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
        w_enc_err   = !w_imm_i_ok;
      end
      FMT_S: begin
        w_enc_instr = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_imm[4:0], r_s1_opcode};
        w_enc_err   = !w_imm_i_ok;
      end
      FMT_B: begin
        w_enc_instr = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                       r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
        w_enc_err   = !w_imm_b_ok;
      end
      FMT_U: begin
        w_enc_instr = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
        w_enc_err   = !w_imm_u_ok;
      end
      FMT_J: begin
        w_enc_instr = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12], r_s1_rd, r_s1_opcode};
        w_enc_err   = !w_imm_j_ok;
      end
      default: w_enc_err = 1'b1;
    endcase
    // Any error forces an all-zero word so consumers never see a partial encoding.
    if (w_enc_err) begin
      w_enc_instr = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_vld    <= 1'b0;
      r_s1_fmt    <= 3'd0;
      r_s1_opcode <= 7'd0;
      r_s1_rd     <= 5'd0;
      r_s1_rs1    <= 5'd0;
      r_s1_rs2    <= 5'd0;
      r_s1_funct3 <= 3'd0;
      r_s1_funct7 <= 7'd0;
      r_s1_imm    <= '0;
    end else if (in_ready) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_fmt    <= in_fmt;
        r_s1_opcode <= in_opcode;
        r_s1_rd     <= in_rd;
        r_s1_rs1    <= in_rs1;
        r_s1_rs2    <= in_rs2;
        r_s1_funct3 <= in_funct3;
        r_s1_funct7 <= in_funct7;
        r_s1_imm    <= in_imm;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_vld   <= 1'b0;
      r_s2_instr <= 32'h0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_instr <= w_enc_instr;
        r_s2_err   <= w_enc_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_cnt <= 16'h0;
      r_err_cnt   <= 8'h0;
    end else begin
      if (w_in_xfer) begin
        r_instr_cnt <= r_instr_cnt + 16'd1;
      end
      if (w_s2_load && r_s1_vld && w_enc_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign out_valid   = r_s2_vld;
  assign out_instr   = r_s2_instr;
  assign out_err     = r_s2_err;
  assign instr_count = r_instr_cnt;
  assign err_count   = r_err_cnt;

endmodule
